// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// State encoding is fixed so that waveforms and debug taps read the same everywhere.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DCNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog: counts stalled cycles within one grant, raises a sticky err at TIMEOUT.
// err is visible in the very stall cycle that reaches TIMEOUT, then held by r_err.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_hit;

  assign w_hit = run && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign err   = r_err | w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (clear) begin
        r_cnt <= '0;
      end else if (run && (r_cnt != CNT_W'(TIMEOUT))) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_hit) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between fetch and data requesters; data wins, bounded by a burst limit.
// Grant is registered (IDLE bubble between accesses) and held until the cache drops m_stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int D_BURST_MAX = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wd,
  output logic              m_re,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rd,
  input  logic              m_stall,
  output logic              busy,
  output logic              err
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic              r_re;
  logic              r_we;
  logic [DCNT_W-1:0] r_dcnt;
  logic              w_d_req;
  logic              w_burst_full;
  logic              w_gnt_d;
  logic              w_gnt_i;
  logic              w_done;
  logic              w_stalled;

  assign w_d_req      = d_re | d_we;
  // Data yields only when it has used up its burst and a fetch is actually waiting.
  assign w_burst_full = (r_dcnt == DCNT_W'(D_BURST_MAX)) && i_req;
  assign w_done       = (r_state != IDLE) && !m_stall;
  assign w_stalled    = (r_state != IDLE) && m_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_d     = 1'b0;
    w_gnt_i     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && !w_burst_full) begin
          w_state_nxt = GNT_D;
          w_gnt_d     = 1'b1;
        end else if (i_req) begin
          w_state_nxt = GNT_I;
          w_gnt_i     = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (!m_stall) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wd    <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_d) begin
        r_addr <= d_addr;
        r_wd   <= d_wdata;
        r_we   <= d_we;
        r_re   <= d_re & ~d_we;
        if (!i_req) begin
          r_dcnt <= '0;
        end else if (r_dcnt != DCNT_W'(D_BURST_MAX)) begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end else if (w_gnt_i) begin
        r_addr <= i_addr;
        r_re   <= 1'b1;
        r_we   <= 1'b0;
        r_dcnt <= '0;
      end else if (w_done) begin
        r_re <= 1'b0;
        r_we <= 1'b0;
      end
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .run  (w_stalled),
    .clear(w_done),
    .err  (err)
  );

  assign i_done  = (r_state == GNT_I) && !m_stall;
  assign d_done  = (r_state == GNT_D) && !m_stall;
  assign i_rdata = i_done ? m_rd : '0;
  assign d_rdata = d_done ? m_rd : '0;
  assign i_stall = i_req & ~i_done;
  assign d_stall = w_d_req & ~d_done;
  assign m_addr  = r_addr;
  assign m_wd    = r_wd;
  assign m_re    = r_re;
  assign m_we    = r_we;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference (owner of the port, latched access, burst and stall counts).
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DBM = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_re, d_we, m_stall;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, m_rd, m_wd, i_rdata, d_rdata;
  logic          i_done, i_stall, d_done, d_stall, m_re, m_we, busy, err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .D_BURST_MAX(DBM), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_addr(m_addr), .m_wd(m_wd), .m_re(m_re), .m_we(m_we),
    .m_rd(m_rd), .m_stall(m_stall), .busy(busy), .err(err)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_stall = 0; m_rd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    adv(); adv();
    rst = 1'b1;
    adv();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    smp();
    vectors++; if ({busy, m_re, m_we, err} !== 4'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {busy, m_re, m_we, err}); end
    vectors++; if (m_addr !== '0) begin miscompares++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
    vectors++; if (m_wd !== '0) begin miscompares++; $display("FAIL reset_m_wd: got %h want 0", m_wd); end
    adv();
    rst = 1'b1;
    adv();
  endtask

  task automatic test_fetch_hit();
    i_req = 1; i_addr = 32'h100; m_stall = 0; m_rd = 32'hDEADBEEF;
    smp();
    vectors++; if ({busy, m_re, i_stall} !== 3'b001) begin miscompares++; $display("FAIL hit_req_cycle: got %b want 001", {busy, m_re, i_stall}); end
    adv(); smp();
    vectors++; if ({m_re, m_we} !== 2'b10) begin miscompares++; $display("FAIL hit_m_re_we: got %b want 10", {m_re, m_we}); end
    vectors++; if (m_addr !== 32'h100) begin miscompares++; $display("FAIL hit_m_addr: got %h want 100", m_addr); end
    vectors++; if ({i_done, d_done, i_stall} !== 3'b100) begin miscompares++; $display("FAIL hit_done: got %b want 100", {i_done, d_done, i_stall}); end
    vectors++; if (i_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL hit_i_rdata: got %h want deadbeef", i_rdata); end
    vectors++; if (d_rdata !== '0) begin miscompares++; $display("FAIL hit_d_rdata: got %h want 0", d_rdata); end
    adv(); i_addr = 32'h104; smp();
    vectors++; if ({busy, m_re, i_done} !== 3'b000) begin miscompares++; $display("FAIL hit_bubble: got %b want 000", {busy, m_re, i_done}); end
    adv(); smp();
    vectors++; if ({i_done, m_addr} !== {1'b1, 32'h104}) begin miscompares++; $display("FAIL hit_second: got %b/%h want 1/104", i_done, m_addr); end
    adv(); i_req = 0;
    adv();
  endtask

  task automatic test_priority();
    do_reset();
    i_req = 1; i_addr = 32'h300; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55; m_stall = 0; m_rd = 32'h1234;
    adv(); smp();
    vectors++; if ({m_we, m_re, d_done, i_done, i_stall} !== 5'b10101) begin miscompares++; $display("FAIL prio_d_first: got %b want 10101", {m_we, m_re, d_done, i_done, i_stall}); end
    vectors++; if ({m_addr, m_wd} !== {32'h200, 32'h55}) begin miscompares++; $display("FAIL prio_d_operands: got %h/%h want 200/55", m_addr, m_wd); end
    adv(); d_we = 0; smp();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL prio_bubble: got %b want 0", busy); end
    adv(); smp();
    vectors++; if ({m_re, m_we, i_done, m_addr} !== {3'b101, 32'h300}) begin miscompares++; $display("FAIL prio_i_second: got %b%b%b/%h want 101/300", m_re, m_we, i_done, m_addr); end
    vectors++; if ({i_rdata, d_rdata} !== {32'h1234, 32'h0}) begin miscompares++; $display("FAIL prio_rdata: got %h/%h want 1234/0", i_rdata, d_rdata); end
    adv(); i_req = 0;
    adv();
  endtask

  task automatic test_miss();
    d_re = 1; d_addr = 32'h400; i_req = 1; i_addr = 32'h480; m_stall = 1; m_rd = 32'hA5A5;
    adv();
    for (int k = 0; k < 20; k++) begin
      if (k == 5) d_addr = 32'h999;
      smp();
      vectors++; if ({m_re, m_we, busy, d_done, i_done, d_stall, i_stall} !== 7'b1010011 || m_addr !== 32'h400) begin
        miscompares++; $display("FAIL miss_hold[%0d]: got %b/%h want 1010011/400", k, {m_re, m_we, busy, d_done, i_done, d_stall, i_stall}, m_addr);
      end
      adv();
    end
    m_stall = 0;
    smp();
    vectors++; if ({d_done, i_done, d_rdata} !== {2'b10, 32'hA5A5}) begin miscompares++; $display("FAIL miss_done: got %b%b/%h want 10/a5a5", d_done, i_done, d_rdata); end
    adv(); d_re = 0; i_req = 0;
    adv();
  endtask

  task automatic test_starvation();
    int n;
    bit want_d;
    do_reset();
    d_re = 1; d_addr = 32'h500; i_req = 1; i_addr = 32'h600; m_stall = 0;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
      smp();
      if (d_done || i_done) begin
        want_d = (n % (DBM + 1)) < DBM;
        vectors++; if ({d_done, i_done} !== {want_d, !want_d}) begin miscompares++; $display("FAIL starve_grant[%0d]: got d%b i%b want d%b i%b", n, d_done, i_done, want_d, !want_d); end
        n++;
      end
      adv();
    end
    vectors++; if (n != 10) begin miscompares++; $display("FAIL starve_timeout: got %0d grants want 10", n); end
    d_re = 0; i_req = 0;
    adv(); adv();
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    d_we = 1; d_addr = 32'h700; d_wdata = 32'h77; m_stall = 1;
    adv(); adv(); smp();
    vectors++; if ({m_we, busy} !== 2'b11) begin miscompares++; $display("FAIL rmid_pre: got %b want 11", {m_we, busy}); end
    rst = 1'b0;
    #1;
    vectors++; if ({m_we, m_re, busy} !== 3'b000) begin miscompares++; $display("FAIL rmid_async: got %b want 000", {m_we, m_re, busy}); end
    clear_inputs();
    adv(); rst = 1'b1;
    smp();
    vectors++; if ({m_we, m_re, busy} !== 3'b000) begin miscompares++; $display("FAIL rmid_after: got %b want 000", {m_we, m_re, busy}); end
    adv();
  endtask

  task automatic test_watchdog();
    do_reset();
    i_req = 1; i_addr = 32'h800; m_stall = 1;
    adv();
    for (int k = 1; k <= 10; k++) begin
      smp();
      vectors++; if (err !== (k >= TMO)) begin miscompares++; $display("FAIL wdog_stall[%0d]: got %b want %b", k, err, (k >= TMO)); end
      adv();
    end
    m_stall = 0;
    smp();
    vectors++; if ({i_done, err} !== 2'b11) begin miscompares++; $display("FAIL wdog_done: got %b want 11", {i_done, err}); end
    adv(); i_req = 0;
    for (int k = 0; k < 3; k++) begin
      smp();
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wdog_sticky[%0d]: got %b want 1", k, err); end
      adv();
    end
    rst = 1'b0;
    #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wdog_reset: got %b want 0", err); end
    adv(); rst = 1'b1;
    adv();
  endtask

  task automatic test_random();
    int            owner;     // 0 = nobody, 1 = fetch, 2 = data
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_re, e_we, e_idone, e_ddone;
    int            burst, run, stall_left, op, r;
    bit            sticky, i_fin, d_fin, e_err;
    logic [7:0]    e_vec, o_vec;
    do_reset();
    owner = 0; burst = 0; run = 0; sticky = 0; i_fin = 0; d_fin = 0; stall_left = 0;
    e_addr = '0; e_wd = '0; e_re = 0; e_we = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_fin || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0); i_addr = $urandom;
      end
      if (d_fin || !(d_re || d_we)) begin
        op = $urandom_range(0, 4);
        d_re = (op == 1 || op == 3); d_we = (op == 2 || op == 3);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (stall_left > 0) begin
        m_stall = 1; stall_left--;
      end else begin
        r = $urandom_range(0, 19);
        m_stall = (r >= 12);
        if (r == 19) stall_left = $urandom_range(4, 11);
      end
      m_rd = $urandom;
      smp();
      e_idone = (owner == 1) && !m_stall;
      e_ddone = (owner == 2) && !m_stall;
      e_err   = sticky || (owner != 0 && m_stall && (run + 1) >= TMO);
      e_vec = {owner != 0, owner != 0 && e_re, owner != 0 && e_we, e_idone, e_ddone,
               i_req && !e_idone, (d_re || d_we) && !e_ddone, e_err};
      o_vec = {busy, m_re, m_we, i_done, d_done, i_stall, d_stall, err};
      vectors++; if (o_vec !== e_vec) begin miscompares++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", c, o_vec, e_vec); end
      vectors++; if (i_rdata !== (e_idone ? m_rd : '0) || d_rdata !== (e_ddone ? m_rd : '0)) begin
        miscompares++; $display("FAIL rnd_rdata[%0d]: got %h/%h done %b%b rd %h", c, i_rdata, d_rdata, e_idone, e_ddone, m_rd);
      end
      if (owner != 0) begin
        vectors++; if (m_addr !== e_addr || (owner == 2 && m_wd !== e_wd)) begin
          miscompares++; $display("FAIL rnd_operands[%0d]: got %h/%h want %h/%h", c, m_addr, m_wd, e_addr, e_wd);
        end
      end
      adv();
      // Model the edge that just passed using the inputs that were present before it.
      i_fin = e_idone; d_fin = e_ddone;
      if (owner != 0) begin
        if (m_stall) begin
          run++;
          if (run >= TMO) sticky = 1;
        end else begin
          owner = 0; run = 0;
        end
      end else if ((d_re || d_we) && !(burst == DBM && i_req)) begin
        owner = 2; e_addr = d_addr; e_wd = d_wdata; e_we = d_we; e_re = d_re && !d_we;
        burst = i_req ? ((burst + 1 > DBM) ? DBM : burst + 1) : 0;
      end else if (i_req) begin
        owner = 1; e_addr = i_addr; e_re = 1; e_we = 0; burst = 0;
      end
    end
    clear_inputs();
    adv(); adv();
  endtask

  initial begin
    test_reset();
    test_fetch_hit();
    test_priority();
    test_miss();
    test_starvation();
    test_reset_mid_miss();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
